// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Fetch stage of the multi-cycle RV32I core. Owns the PC and the instruction register.
//   It issues one word fetch at a time over a req/ready handshake, holds the fetched word
//   for decode, and advances or redirects the PC when control retires the held instruction.
//
// Ports
//   clk, rst                 core clock; synchronous active-high reset
//   imem_req/addr            fetch request and word address (addr == pc at all times)
//   imem_ready/rdata         memory response; rdata is taken in the cycle ready is high
//   ir_valid, inst, pc_out   held instruction, its valid flag, and its PC
//   ir_accept                control retires the held instruction
//   redirect_en/redirect_pc  with ir_accept: branch/jump target instead of pc+4
//   flush/flush_pc           abandon current work and restart at flush_pc
//   fetch_fault              misaligned target trapped (trap build only, otherwise 0)
//
// Configuration
//   FETCH_MISALIGN_TRAP_EN   when defined, a redirect/flush target with bits[1:0] != 0 parks
//                            the unit in a fault state until reset. When undefined, the low
//                            two target bits are simply cleared.

module inst_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        ir_valid,
    output logic [31:0] inst,
    output logic [31:0] pc_out,
    input  logic        ir_accept,
    input  logic        redirect_en,
    input  logic [31:0] redirect_pc,
    input  logic        flush,
    input  logic [31:0] flush_pc,
    output logic        fetch_fault
);

`ifdef FETCH_MISALIGN_TRAP_EN
    typedef enum logic [1:0] {StReq, StHold, StDrain, StFault} state_e;
`else
    typedef enum logic [1:0] {StReq, StHold, StDrain} state_e;
`endif

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic        ir_valid_q, ir_valid_d;
    logic [31:0] drop_q, drop_d;      // restart target while draining an abandoned fetch
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault_q, fault_d;
`endif

    // Common "jump to target" path shared by redirect, flush and drain completion.
    logic        load_en;
    logic [31:0] load_tgt;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StReq;
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            ir_valid_q <= 1'b0;
            drop_q     <= 32'h0000_0000;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            ir_valid_q <= ir_valid_d;
            drop_q     <= drop_d;
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q    <= fault_d;
`endif
        end
    end

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        inst_d     = inst_q;
        ir_valid_d = ir_valid_q;
        drop_d     = drop_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d    = fault_q;
`endif
        load_en    = 1'b0;
        load_tgt   = 32'h0000_0000;

        unique case (state_q)
            StReq: begin
                if (imem_ready) begin
                    if (flush) begin
                        // Response arrives with the flush: the handshake completes, so the
                        // word is dropped and the new target loaded directly.
                        load_en  = 1'b1;
                        load_tgt = flush_pc;
                        inst_d   = NOP_INST;
                    end else begin
                        inst_d     = imem_rdata;
                        ir_valid_d = 1'b1;
                        state_d    = StHold;
                    end
                end else if (flush) begin
                    // Request cannot be withdrawn; finish it, then restart.
                    drop_d  = flush_pc;
                    state_d = StDrain;
                end
            end
            StHold: begin
                if (flush) begin
                    load_en  = 1'b1;
                    load_tgt = flush_pc;
                    inst_d   = NOP_INST;
                end else if (ir_accept) begin
                    if (redirect_en) begin
                        load_en  = 1'b1;
                        load_tgt = redirect_pc;
                    end else begin
                        pc_d       = pc_q + 32'd4;
                        ir_valid_d = 1'b0;
                        state_d    = StReq;
                    end
                end
            end
            StDrain: begin
                if (imem_ready) begin
                    // A flush in the completing cycle supersedes the stored target.
                    load_en  = 1'b1;
                    load_tgt = flush ? flush_pc : drop_q;
                end else if (flush) begin
                    drop_d = flush_pc;
                end
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            StFault: begin
                ir_valid_d = 1'b0;
            end
`endif
            default: begin
                state_d    = StReq;
                ir_valid_d = 1'b0;
            end
        endcase

        if (load_en) begin
            ir_valid_d = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (load_tgt[1:0] != 2'b00) begin
                fault_d = 1'b1;
                state_d = StFault;
            end else begin
                pc_d    = load_tgt;
                state_d = StReq;
            end
`else
            pc_d    = load_tgt & 32'hFFFF_FFFC;
            state_d = StReq;
`endif
        end
    end

    // Outputs
    always_comb begin
        imem_req = (state_q == StReq) || (state_q == StDrain);
    end

    assign imem_addr = pc_q;
    assign pc_out    = pc_q;
    assign inst      = inst_q;
    assign ir_valid  = ir_valid_q;
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fetch_fault = fault_q;
`else
    assign fetch_fault = 1'b0;
`endif

endmodule
